// File: rtl/vga_scanout.sv
// VGA scan-out of a 1bpp framebuffer read through the RAM video port, pixels upscaled SCALE x SCALE.
// Latency: 3 clocks from counter state to pins (va register, RAM read register, output register).
// No backpressure: the RAM port answers every cycle; en low holds counters at 0 and blanks all outputs.
module vga_scanout #(
    parameter int          CLK_DIV = 2,
    parameter int          H_VIS   = 640,
    parameter int          H_FP    = 16,
    parameter int          H_SYNC  = 96,
    parameter int          H_BP    = 48,
    parameter int          V_VIS   = 480,
    parameter int          V_FP    = 10,
    parameter int          V_SYNC  = 2,
    parameter int          V_BP    = 33,
    parameter int          SCALE   = 20,
    parameter logic [31:0] FB_BASE = 32'h300,
    parameter logic [11:0] FG_RGB  = 12'hFFF,
    parameter logic [11:0] BG_RGB  = 12'h000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_en,
    output logic [31:0] o_va,
    input  logic [31:0] i_vd,
    output logic [3:0]  o_vga_r,
    output logic [3:0]  o_vga_g,
    output logic [3:0]  o_vga_b,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_de,
    output logic        o_frame_start
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int WPR   = ((H_VIS / SCALE) + 31) / 32;
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SW    = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [SW-1:0] S_LAST   = SW'(SCALE - 1);
    localparam logic [9:0]    H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0]    H_VIS_L  = 10'(H_VIS);
    localparam logic [9:0]    V_VIS_L  = 10'(V_VIS);
    localparam logic [9:0]    V_PRELAST = 10'(V_VIS - 1);
    localparam logic [9:0]    HS_BEG   = 10'(H_VIS + H_FP);
    localparam logic [9:0]    HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0]    VS_BEG   = 10'(V_VIS + V_FP);
    localparam logic [9:0]    VS_END   = 10'(V_VIS + V_FP + V_SYNC);

    logic [DW-1:0] r_div;
    logic [9:0]    r_h, r_v, r_fx, r_fy;
    logic [SW-1:0] r_sx, r_sy;

    logic [4:0]    r_s1_bit, r_s2_bit;
    logic          r_s1_de, r_s1_hs, r_s1_vs, r_s1_fs;
    logic          r_s2_de, r_s2_hs, r_s2_vs, r_s2_fs;
    logic [31:0]   r_va;
    logic [11:0]   r_rgb;
    logic          r_de, r_hs, r_vs, r_fs;

    logic          w_h_vis, w_v_vis, w_vis, w_hs_n, w_vs_n, w_fs;
    logic [9:0]    w_afx, w_afy, w_fy_next;
    logic [31:0]   w_word, w_va;
    logic [4:0]    w_bit;

    // Pixel divider, screen counters and framebuffer sub-counters (fx=h/SCALE, fy=v/SCALE)
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_div <= '0; r_h <= '0; r_v <= '0;
            r_sx  <= '0; r_fx <= '0; r_sy <= '0; r_fy <= '0;
        end else if (!i_en) begin
            r_div <= '0; r_h <= '0; r_v <= '0;
            r_sx  <= '0; r_fx <= '0; r_sy <= '0; r_fy <= '0;
        end else if (r_div != DIV_LAST) begin
            r_div <= r_div + DW'(1);
        end else begin
            r_div <= '0;
            if (r_h == H_LAST) begin
                r_h  <= '0;
                r_sx <= '0;
                r_fx <= '0;
                if (r_v == V_LAST) begin
                    r_v  <= '0;
                    r_sy <= '0;
                    r_fy <= '0;
                end else begin
                    r_v <= r_v + 10'd1;
                    if (r_sy == S_LAST) begin
                        r_sy <= '0;
                        r_fy <= r_fy + 10'd1;
                    end else begin
                        r_sy <= r_sy + SW'(1);
                    end
                end
            end else begin
                r_h <= r_h + 10'd1;
                if (r_sx == S_LAST) begin
                    r_sx <= '0;
                    r_fx <= r_fx + 10'd1;
                end else begin
                    r_sx <= r_sx + SW'(1);
                end
            end
        end
    end

    // Address, bit index and timing flags for the current counter state; in blanking the
    // address already points at the first word of the next visible line so reads stay in range
    always_comb begin
        w_h_vis   = (r_h < H_VIS_L);
        w_v_vis   = (r_v < V_VIS_L);
        w_vis     = w_h_vis && w_v_vis;
        w_fy_next = (r_sy == S_LAST) ? (r_fy + 10'd1) : r_fy;
        if (w_vis)
            w_afy = r_fy;
        else if (!w_h_vis && (r_v < V_PRELAST))
            w_afy = w_fy_next;
        else
            w_afy = '0;
        w_afx  = w_vis ? r_fx : '0;
        w_word = (32'(w_afy) * 32'(WPR)) + 32'(w_afx >> 5);
        w_va   = FB_BASE + (w_word << 2);
        w_bit  = 5'd31 - r_fx[4:0];
        w_hs_n = !((r_h >= HS_BEG) && (r_h < HS_END));
        w_vs_n = !((r_v >= VS_BEG) && (r_v < VS_END));
        w_fs   = (r_h == 10'd0) && (r_v == 10'd0) && (r_div == '0);
    end

    // S1: register the video address and the per-pixel controls that travel with it
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_va <= FB_BASE; r_s1_bit <= '0; r_s1_de <= 1'b0;
            r_s1_hs <= 1'b1; r_s1_vs <= 1'b1; r_s1_fs <= 1'b0;
        end else if (!i_en) begin
            r_va <= FB_BASE; r_s1_bit <= '0; r_s1_de <= 1'b0;
            r_s1_hs <= 1'b1; r_s1_vs <= 1'b1; r_s1_fs <= 1'b0;
        end else begin
            r_va <= w_va; r_s1_bit <= w_bit; r_s1_de <= w_vis;
            r_s1_hs <= w_hs_n; r_s1_vs <= w_vs_n; r_s1_fs <= w_fs;
        end
    end

    // S2: controls wait one clock while the RAM registers the read data
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_s2_bit <= '0; r_s2_de <= 1'b0; r_s2_hs <= 1'b1; r_s2_vs <= 1'b1; r_s2_fs <= 1'b0;
        end else if (!i_en) begin
            r_s2_bit <= '0; r_s2_de <= 1'b0; r_s2_hs <= 1'b1; r_s2_vs <= 1'b1; r_s2_fs <= 1'b0;
        end else begin
            r_s2_bit <= r_s1_bit; r_s2_de <= r_s1_de; r_s2_hs <= r_s1_hs;
            r_s2_vs <= r_s1_vs; r_s2_fs <= r_s1_fs;
        end
    end

    // S3: pick the pixel bit from the returned word and register all pin outputs together
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rgb <= '0; r_de <= 1'b0; r_hs <= 1'b1; r_vs <= 1'b1; r_fs <= 1'b0;
        end else if (!i_en) begin
            r_rgb <= '0; r_de <= 1'b0; r_hs <= 1'b1; r_vs <= 1'b1; r_fs <= 1'b0;
        end else begin
            r_rgb <= r_s2_de ? (i_vd[r_s2_bit] ? FG_RGB : BG_RGB) : 12'h000;
            r_de  <= r_s2_de;
            r_hs  <= r_s2_hs;
            r_vs  <= r_s2_vs;
            r_fs  <= r_s2_fs;
        end
    end

    assign o_va          = r_va;
    assign o_vga_r       = r_rgb[11:8];
    assign o_vga_g       = r_rgb[7:4];
    assign o_vga_b       = r_rgb[3:0];
    assign o_hsync       = r_hs;
    assign o_vsync       = r_vs;
    assign o_de          = r_de;
    assign o_frame_start = r_fs;
endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout on a reduced geometry so a whole frame fits in a short run.
// Line = 160 px (128 vis, hsync px 136..151) x CLK_DIV 2 = 320 clk; frame = 20 lines (12 vis, vsync lines 14,15).
// SCALE 2 gives 64 framebuffer pixels per line, i.e. two words per framebuffer row.
module tb_vga_scanout;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic [31:0] va;
    logic [31:0] vd;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        hsync, vsync, de, frame_start;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:15];

    vga_scanout #(
        .CLK_DIV(2), .H_VIS(128), .H_FP(8), .H_SYNC(16), .H_BP(8),
        .V_VIS(12), .V_FP(2), .V_SYNC(2), .V_BP(4), .SCALE(2),
        .FB_BASE(32'h300), .FG_RGB(12'hFFF), .BG_RGB(12'h000)
    ) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_en(en),
        .o_va(va), .i_vd(vd),
        .o_vga_r(vga_r), .o_vga_g(vga_g), .o_vga_b(vga_b),
        .o_hsync(hsync), .o_vsync(vsync), .o_de(de), .o_frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // RAM video port: registered read, one clock after va
    logic [31:0] va_off;
    assign va_off = va - 32'h300;
    always @(posedge clk) vd <= mem[va_off[5:2]];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [127:0] lines [0:5];
    int de_clks, de_bad, rgb_bad, hs_clks, hs_first, vs_clks, vs_first, fs_cnt, fs_cnt2, misalign;
    logic [31:0] va_min, va_max, va_a, va_b, va_c, va_d, va_e, va_f, va_g, va_h;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0] = 32'h8000_0001;   // row 0, fx 0..31
        mem[1] = 32'hC000_0000;   // row 0, fx 32..63
        mem[2] = 32'h0F00_0000;   // row 1, fx 4..7
        mem[5] = 32'h0000_0001;   // row 2, fx 63
        mem[11] = 32'h1234_5678;
        for (int i = 0; i < 6; i++) lines[i] = '0;
        de_clks = 0; de_bad = 0; rgb_bad = 0; hs_clks = 0; hs_first = -1;
        vs_clks = 0; vs_first = -1; fs_cnt = 0; fs_cnt2 = 0; misalign = 0;
        va_min = 32'hFFFF_FFFF; va_max = 32'h0;
        va_a = 0; va_b = 0; va_c = 0; va_d = 0; va_e = 0; va_f = 0; va_g = 0; va_h = 0;

        // Reset state
        reset_n = 1'b0;
        en      = 1'b0;
        step(3);
        chk("rst_va", va, 32'h300);
        chk("rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        chk("rst_hsync", hsync, 1'b1);
        chk("rst_vsync", vsync, 1'b1);
        chk("rst_de", de, 1'b0);
        chk("rst_fs", frame_start, 1'b0);

        // First pixel reaches the pins on the third clock after enabling
        reset_n = 1'b1;
        en      = 1'b1;
        step(2);
        chk("start_de_early", de, 1'b0);
        chk("start_fs_early", frame_start, 1'b0);
        step(1);
        chk("start_de", de, 1'b1);
        chk("start_fs", frame_start, 1'b1);

        // One full frame, output clock c shows pixel h=(c/2)%160, line v=c/320
        for (int c = 0; c < 6400; c++) begin
            int h, v;
            logic de_exp;
            h = (c / 2) % 160;
            v = c / 320;
            de_exp = (h < 128) && (v < 12);
            if (de) de_clks++;
            if (de !== de_exp) de_bad++;
            if (!de && ({vga_r, vga_g, vga_b} != 12'h000)) rgb_bad++;
            if (!hsync) begin hs_clks++; if (hs_first < 0) hs_first = c; end
            if (!vsync) begin vs_clks++; if (vs_first < 0) vs_first = c; end
            if (frame_start) fs_cnt++;
            if (v < 6 && h < 128 && (c % 2) == 0) lines[v][h] = ({vga_r, vga_g, vga_b} == 12'hFFF);
            if (va[1:0] != 2'b00) misalign++;
            if (va < va_min) va_min = va;
            if (va > va_max) va_max = va;
            if (c == 124)  va_a = va;
            if (c == 126)  va_b = va;
            if (c == 278)  va_c = va;
            if (c == 598)  va_d = va;
            if (c == 638)  va_e = va;
            if (c == 3772) va_f = va;
            if (c == 3798) va_g = va;
            if (c == 4818) va_h = va;
            // Scribble over row 0 during vertical blank, restore before it is read again
            if (c == 4000) mem[0] = 32'hFFFF_FFFF;
            if (c == 6000) mem[0] = 32'h8000_0001;
            step(1);
        end
        chk("frame_len_fs", frame_start, 1'b1);
        chk("fs_per_frame", fs_cnt, 1);
        chk("de_clks", de_clks, 3072);
        chk("de_placement", de_bad, 0);
        chk("rgb_in_blank", rgb_bad, 0);
        chk("hs_clks", hs_clks, 640);
        chk("hs_first", hs_first, 272);
        chk("vs_clks", vs_clks, 640);
        chk("vs_first", vs_first, 4480);
        chk("line0", lines[0], 128'h0000_0000_0000_000F_C000_0000_0000_0003);
        chk("line1", lines[1], 128'h0000_0000_0000_000F_C000_0000_0000_0003);
        chk("line2", lines[2], 128'h0000_0000_0000_0000_0000_0000_0000_FF00);
        chk("line3", lines[3], 128'h0000_0000_0000_0000_0000_0000_0000_FF00);
        chk("line4", lines[4], 128'hC000_0000_0000_0000_0000_0000_0000_0000);
        chk("line5", lines[5], 128'hC000_0000_0000_0000_0000_0000_0000_0000);
        chk("va_fx31", va_a, 32'h300);
        chk("va_fx32", va_b, 32'h304);
        chk("va_hblank_l0", va_c, 32'h300);
        chk("va_hblank_l1", va_d, 32'h308);
        chk("va_row1", va_e, 32'h308);
        chk("va_last_word", va_f, 32'h32C);
        chk("va_hblank_last", va_g, 32'h300);
        chk("va_vblank", va_h, 32'h300);
        chk("va_min", va_min, 32'h300);
        chk("va_max", va_max, 32'h32C);
        chk("va_align", misalign, 0);

        // Drop en mid-line while hsync is active
        step(280);
        chk("hs_active", hsync, 1'b0);
        en = 1'b0;
        step(1);
        chk("off_de", de, 1'b0);
        chk("off_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        chk("off_hsync", hsync, 1'b1);
        chk("off_vsync", vsync, 1'b1);
        chk("off_fs", frame_start, 1'b0);
        chk("off_va", va, 32'h300);
        step(4);

        // Raise en: scan restarts at (0,0)
        en = 1'b1;
        step(2);
        chk("re_fs_early", frame_start, 1'b0);
        chk("re_de_early", de, 1'b0);
        step(1);
        chk("re_fs", frame_start, 1'b1);
        chk("re_de", de, 1'b1);
        chk("re_px0", {vga_r, vga_g, vga_b}, 12'hFFF);
        for (int k = 0; k < 128; k++) begin
            step(1);
            if (frame_start) fs_cnt2++;
        end
        chk("re_fs_once", fs_cnt2, 0);
        chk("re_px64", {vga_r, vga_g, vga_b}, 12'hFFF);
        chk("re_va_px65", va, 32'h304);

        // Asynchronous reset mid-line takes effect without a clock edge
        reset_n = 1'b0;
        #1;
        chk("arst_va", va, 32'h300);
        chk("arst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        chk("arst_de", de, 1'b0);
        chk("arst_hsync", hsync, 1'b1);
        chk("arst_vsync", vsync, 1'b1);
        chk("arst_fs", frame_start, 1'b0);
        step(2);
        reset_n = 1'b1;
        step(2);
        chk("rel_de_early", de, 1'b0);
        step(1);
        chk("rel_de", de, 1'b1);
        chk("rel_fs", frame_start, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
